// File: rtl/rtc_pkg.sv
// Shared constants for the front-panel button conditioning path.
package rtc_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam int unsigned BTN_TEST = 0;
    localparam int unsigned BTN_HR   = 1;
    localparam int unsigned BTN_MIN  = 2;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, counter debouncer, press pulse and hold-to-repeat stepper.
module btn_channel
    import rtc_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC  = 500000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 12500000,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press,
    output logic step
);

    localparam int unsigned MAX_AB  = (DEBOUNCE_CYC > REPEAT_DELAY) ? DEBOUNCE_CYC : REPEAT_DELAY;
    localparam int unsigned MAX_ALL = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int unsigned CNT_W   = $clog2(MAX_ALL) + 1;

    logic [1:0]       sync_ff;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_nxt;
    logic             level_nxt;
    logic             rise_c;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_cnt_nxt;
    logic             step_nxt;

    // Debounce: accept the synchronised level after DEBOUNCE_CYC consecutive differing cycles.
    always_comb begin
        level_nxt   = level;
        deb_cnt_nxt = '0;
        if (sync_ff[1] != level) begin
            if (deb_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
                level_nxt = sync_ff[1];
            end else begin
                deb_cnt_nxt = deb_cnt + CNT_W'(1);
            end
        end
    end

    assign rise_c = level_nxt & ~level;

    // Repeat FSM looks at the next level so a release on a firing cycle suppresses the pulse.
    always_comb begin
        state_nxt   = state;
        rep_cnt_nxt = rep_cnt;
        step_nxt    = 1'b0;
        if (!REPEAT_EN) begin
            state_nxt   = ST_IDLE;
            rep_cnt_nxt = '0;
            step_nxt    = rise_c;
        end else if (!level_nxt) begin
            state_nxt   = ST_IDLE;
            rep_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rise_c) begin
                        state_nxt   = ST_DELAY;
                        rep_cnt_nxt = '0;
                        step_nxt    = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (rep_cnt == CNT_W'(REPEAT_DELAY - 1)) begin
                        state_nxt   = ST_REPEAT;
                        rep_cnt_nxt = '0;
                        step_nxt    = 1'b1;
                    end else begin
                        rep_cnt_nxt = rep_cnt + CNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (rep_cnt == CNT_W'(REPEAT_PERIOD - 1)) begin
                        rep_cnt_nxt = '0;
                        step_nxt    = 1'b1;
                    end else begin
                        rep_cnt_nxt = rep_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    rep_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_ff <= '0;
            level   <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
            state   <= ST_IDLE;
            rep_cnt <= '0;
            step    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[0], raw};
            level   <= level_nxt;
            deb_cnt <= deb_cnt_nxt;
            press   <= rise_c;
            state   <= state_nxt;
            rep_cnt <= rep_cnt_nxt;
            step    <= step_nxt;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: one independent btn_channel per button.
module button_conditioner
    import rtc_pkg::*;
#(
    parameter int unsigned       N_BTN         = 3,
    parameter int unsigned       DEBOUNCE_CYC  = 500000,
    parameter int unsigned       REPEAT_DELAY  = 50000000,
    parameter int unsigned       REPEAT_PERIOD = 12500000,
    parameter logic [N_BTN-1:0]  REPEAT_MASK   = 3'b110
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_raw_i,
    output logic [N_BTN-1:0] level_o,
    output logic [N_BTN-1:0] press_o,
    output logic [N_BTN-1:0] step_o
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYC  (DEBOUNCE_CYC),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD),
            .REPEAT_EN     (REPEAT_MASK[i])
        ) u_chan (
            .clk   (clk_i),
            .rst   (rst_i),
            .raw   (btn_raw_i[i]),
            .level (level_o[i]),
            .press (press_o[i]),
            .step  (step_o[i])
        );
    end

endmodule
